// File: rtl/qpsk_demod_param_if.sv
// Stream bundle for the fs/4 QPSK/BPSK demodulator: sample input, symbol results and bit output.
interface qpsk_demod_param_if #(
    parameter int IN_W = 10,
    parameter int SPS  = 8
);
    localparam int ACC_W = IN_W + $clog2(SPS) + 1;

    logic                    in_valid;
    logic signed [IN_W-1:0]  in_sample;
    logic                    sym_align;
    logic                    mode;
    logic signed [ACC_W-1:0] i_acc;
    logic signed [ACC_W-1:0] q_acc;
    logic                    sym_strobe;
    logic                    out_valid;
    logic                    out_bit;
    logic                    out_ready;
    logic                    overflow;

    modport master (
        output in_valid, in_sample, sym_align, mode, out_ready,
        input  i_acc, q_acc, sym_strobe, out_valid, out_bit, overflow
    );

    modport slave (
        input  in_valid, in_sample, sym_align, mode, out_ready,
        output i_acc, q_acc, sym_strobe, out_valid, out_bit, overflow
    );
endinterface

// File: rtl/qpsk_demod_param.sv
// fs/4 carrier QPSK/BPSK demodulator: quadrature mix, integrate-and-dump per symbol,
// sign decisions pushed into a small bit FIFO.
module qpsk_demod_param #(
    parameter int IN_W       = 10,
    parameter int SPS        = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    qpsk_demod_param_if.slave bus
);
    localparam int ACC_W = IN_W + $clog2(SPS) + 1;
    localparam int S_W   = $clog2(SPS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [S_W-1:0]          s;
    logic [S_W-1:0]          s_eff;
    logic [1:0]              p;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic signed [ACC_W-1:0] base_i, base_q;
    logic signed [ACC_W-1:0] x_ext, prod_i, prod_q, sum_i, sum_q;
    logic signed [ACC_W-1:0] i_out, q_out;
    logic                    strobe, ovf, dump, push_ok;
    logic                    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [CNT_W-1:0]        count, free, n_want, n_push, n_pop;

    always_comb begin
        // SPS is a multiple of 4, so the carrier phase is simply the low bits of s
        s_eff  = bus.sym_align ? '0 : s;
        p      = s_eff[1:0];
        base_i = bus.sym_align ? '0 : acc_i;
        base_q = bus.sym_align ? '0 : acc_q;
        x_ext  = {{(ACC_W-IN_W){bus.in_sample[IN_W-1]}}, bus.in_sample};
        prod_i = '0;
        prod_q = '0;
        case (p)
            2'd0: prod_i = x_ext;
            2'd1: prod_q = x_ext;
            2'd2: prod_i = -x_ext;
            default: prod_q = -x_ext;
        endcase
        sum_i   = base_i + prod_i;
        sum_q   = base_q + prod_q;
        dump    = bus.in_valid && (s_eff == S_W'(SPS - 1));
        n_pop   = (count != '0 && bus.out_ready) ? CNT_W'(1) : '0;
        n_want  = bus.mode ? CNT_W'(1) : CNT_W'(2);
        free    = CNT_W'(FIFO_DEPTH) - count;
        push_ok = dump && (n_want <= free);
        n_push  = push_ok ? n_want : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s      <= '0;
            acc_i  <= '0;
            acc_q  <= '0;
            i_out  <= '0;
            q_out  <= '0;
            strobe <= 1'b0;
            ovf    <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            strobe <= dump;
            if (bus.in_valid) begin
                if (dump) begin
                    i_out <= sum_i;
                    q_out <= sum_q;
                    acc_i <= '0;
                    acc_q <= '0;
                    s     <= '0;
                end else begin
                    acc_i <= sum_i;
                    acc_q <= sum_q;
                    s     <= s_eff + S_W'(1);
                end
            end else if (bus.sym_align) begin
                acc_i <= '0;
                acc_q <= '0;
                s     <= '0;
            end
            if (dump && !push_ok)
                ovf <= 1'b1;
            wr_ptr <= wr_ptr + PTR_W'(n_push);
            rd_ptr <= rd_ptr + PTR_W'(n_pop);
            count  <= count + n_push - n_pop;
        end
    end

    // FIFO storage needs no reset: out_bit is masked while empty
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem[wr_ptr] <= ~sum_i[ACC_W-1];
            if (!bus.mode)
                mem[wr_ptr + PTR_W'(1)] <= ~sum_q[ACC_W-1];
        end
    end

    assign bus.i_acc      = i_out;
    assign bus.q_acc      = q_out;
    assign bus.sym_strobe = strobe;
    assign bus.overflow   = ovf;
    assign bus.out_valid  = (count != '0);
    assign bus.out_bit    = (count != '0) && mem[rd_ptr];
endmodule

// File: tb/tb_qpsk_demod_param.sv
// Scoreboard bench for qpsk_demod_param: a sample-list reference model pushes expected
// symbol results and bits; a negedge monitor pops and compares against the DUT.
module tb_qpsk_demod_param;
    localparam int IN_W  = 10;
    localparam int SPS   = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qpsk_demod_param_if #(.IN_W(IN_W), .SPS(SPS)) bus ();

    qpsk_demod_param #(.IN_W(IN_W), .SPS(SPS), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int samp[$];
    int exp_i[$];
    int exp_q[$];
    bit exp_bits[$];
    int occ = 0;
    bit ovf_m = 0;
    bit strobe_m = 0;
    bit rst_m = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: symbols are just lists of accepted samples; phase = position mod 4
    always @(posedge clk) begin
        int pops, pushes, si, sq, nb;
        if (rst) begin
            samp.delete();
            exp_i.delete();
            exp_q.delete();
            exp_bits.delete();
            occ = 0;
            ovf_m = 0;
            strobe_m = 0;
            rst_m = 1;
        end else begin
            rst_m = 0;
            strobe_m = 0;
            pushes = 0;
            pops = (occ > 0 && bus.out_ready) ? 1 : 0;
            if (bus.sym_align) samp.delete();
            if (bus.in_valid) begin
                samp.push_back(int'(bus.in_sample));
                if (samp.size() == SPS) begin
                    si = 0;
                    sq = 0;
                    foreach (samp[k]) begin
                        case (k % 4)
                            0: si += samp[k];
                            1: sq += samp[k];
                            2: si -= samp[k];
                            default: sq -= samp[k];
                        endcase
                    end
                    samp.delete();
                    exp_i.push_back(si);
                    exp_q.push_back(sq);
                    strobe_m = 1;
                    nb = bus.mode ? 1 : 2;
                    if (nb > DEPTH - occ) begin
                        ovf_m = 1;
                    end else begin
                        exp_bits.push_back(si >= 0);
                        if (nb == 2) exp_bits.push_back(sq >= 0);
                        pushes = nb;
                    end
                end
            end
            occ = occ + pushes - pops;
        end
    end

    // Monitor
    initial begin
        bit prev_hold = 0;
        bit prev_bit = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (rst_m) begin
                chk("rst_i_acc", bus.i_acc, 0);
                chk("rst_q_acc", bus.q_acc, 0);
                chk("rst_out_bit", bus.out_bit, 0);
            end
            chk("sym_strobe", bus.sym_strobe, strobe_m);
            chk("out_valid", bus.out_valid, occ > 0);
            chk("overflow", bus.overflow, ovf_m);
            if (bus.sym_strobe) begin
                if (exp_i.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    chk("i_acc", int'(bus.i_acc), exp_i.pop_front());
                    chk("q_acc", int'(bus.q_acc), exp_q.pop_front());
                end
            end
            if (prev_hold && bus.out_valid) chk("out_bit_hold", bus.out_bit, prev_bit);
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_bit = bus.out_bit;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_bits.size() == 0) chk("unexpected_bit", 1, 0);
                else chk("out_bit", bus.out_bit, exp_bits.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int x, input bit v = 1'b1, input bit al = 1'b0);
        bus.in_valid = v;
        bus.in_sample = IN_W'(x);
        bus.sym_align = al;
        tick();
        bus.in_valid = 1'b0;
        bus.sym_align = 1'b0;
    endtask

    task automatic pat(input int a, input int b, input int c, input int d);
        for (int r = 0; r < SPS / 4; r++) begin
            send(a); send(b); send(c); send(d);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic int rnd_sample();
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sample = '0;
        bus.sym_align = 1'b0;
        bus.mode = 1'b0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        bus.mode = 1'b0;
        pat(100, 50, -100, -50);
        idle(4);
        bus.mode = 1'b1;
        pat(-100, -50, 100, 50);
        idle(4);
        bus.mode = 1'b0;
        pat(-512, 0, 511, 0);
        pat(0, 0, 0, 0);
        idle(4);

        // Backpressure: two symbols fill the FIFO, the third is dropped
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3 * SPS; k++) send(rnd_sample());
        idle(3);
        bus.out_ready = 1'b1;
        idle(6);

        // Realign mid-symbol, then a reset mid-symbol with competing inputs
        for (int k = 0; k < 5; k++) send(rnd_sample());
        send(rnd_sample(), 1'b1, 1'b1);
        for (int k = 0; k < SPS - 1; k++) send(rnd_sample());
        idle(2);
        for (int k = 0; k < 3; k++) send(rnd_sample());
        rst = 1'b1;
        send(rnd_sample(), 1'b1, 1'b1);
        rst = 1'b0;
        for (int k = 0; k < SPS; k++) send(rnd_sample());
        idle(3);

        for (int k = 0; k < 2 * SPS; k++) begin
            send(rnd_sample(), 1'b1);
            send(rnd_sample(), 1'b0);
        end
        idle(3);

        for (int k = 0; k < 3000; k++) begin
            bus.mode = $urandom_range(0, 1) == 1;
            bus.out_ready = $urandom_range(0, 9) < 7;
            send(rnd_sample(), $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        bus.out_ready = 1'b1;
        for (int k = 0; k < 100 && occ > 0; k++) tick();
        idle(2);
        chk("drain_timeout", occ, 0);
        chk("pending_symbols", exp_i.size(), 0);
        chk("pending_bits", exp_bits.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/qpsk_demod_param.md
QPSK_DEMOD_PARAM -- requirements
Module: qpsk_demod_param

Interface
REQ-001 The module SHALL have parameter IN_W, default 10, meaning the signed input sample width.
REQ-002 The module SHALL have parameter SPS, default 8, meaning samples per symbol; it SHALL be a multiple of 4 and at least 4.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, meaning output bit FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-004 The module SHALL have a derived local parameter ACC_W = IN_W + clog2(SPS) + 1.
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-007 The module SHALL have port in_valid, input, 1 bit, which qualifies in_sample.
REQ-008 The module SHALL have port in_sample, input, IN_W bits, a signed received passband sample, with carrier = fs/4.
REQ-009 The module SHALL have port sym_align, input, 1 bit, which restarts symbol and carrier phase.
REQ-010 The module SHALL have port mode, input, 1 bit, where 0 = QPSK (2 bits/symbol) and 1 = BPSK (1 bit/symbol).
REQ-011 The module SHALL have port i_acc, output, ACC_W bits, the signed I integrate-and-dump result of the last symbol.
REQ-012 The module SHALL have port q_acc, output, ACC_W bits, the signed Q integrate-and-dump result of the last symbol.
REQ-013 The module SHALL have port sym_strobe, output, 1 bit, which pulses for 1 cycle when i_acc/q_acc update.
REQ-014 The module SHALL have port out_valid, output, 1 bit, high when the FIFO is non-empty.
REQ-015 The module SHALL have port out_bit, output, 1 bit, the FIFO head bit.
REQ-016 The module SHALL have port out_ready, input, 1 bit, the consumer accept signal.
REQ-017 The module SHALL have port overflow, output, 1 bit, a sticky flag marking a dropped symbol.

Function
REQ-018 The module SHALL advance carrier phase counter p (0..3, wraps) and sample counter s (0..SPS-1, wraps) only on accepted samples (in_valid=1).
REQ-019 The I-mix product SHALL be +x at p=0, 0 at p=1, -x at p=2 and 0 at p=3; the Q-mix product SHALL be 0 at p=0, +x at p=1, 0 at p=2 and -x at p=3; x SHALL be sign-extended to ACC_W before negation, so -(-2^(IN_W-1)) is exact.
REQ-020 The I and Q accumulators SHALL sum the mix products of accepted samples with no saturation (ACC_W guarantees no overflow).
REQ-021 On the edge accepting the sample with s=SPS-1 (the dump), i_acc/q_acc SHALL load the accumulator plus the current product, the accumulators SHALL clear, sym_strobe SHALL be 1 for the following cycle, and the FIFO push SHALL occur on the same edge.
REQ-022 The decision rule SHALL be bit = 1 if acc >= 0 and 0 if acc < 0, so zero maps to 1.
REQ-023 In QPSK the module SHALL push the I bit then the Q bit (I reaches the head first) in one cycle; in BPSK it SHALL push the I bit only, and Q SHALL still be accumulated and reported.
REQ-024 mode SHALL be sampled at the dump edge only.
REQ-025 If free entries (FIFO_DEPTH - count, a pop on the same edge not counted) are fewer than the bits to push, the whole symbol SHALL be dropped, overflow SHALL be set to 1 and held until rst, and i_acc/q_acc/sym_strobe SHALL still update.
REQ-026 A pop SHALL occur on an edge with out_valid=1 and out_ready=1; simultaneous push and pop SHALL be legal, with count changing by pushes - pops.
REQ-027 out_valid SHALL be 1 in the cycle after a push to an empty FIFO; the latency from the last-sample edge to out_valid SHALL be 1 cycle.
REQ-028 out_bit SHALL be stable while out_valid=1 and out_ready=0.
REQ-029 A cycle with sym_align=1 SHALL clear p, s and the accumulators; if in_valid=1 in the same cycle, that sample SHALL be processed as p=0, s=0 of a new symbol.
REQ-030 sym_align SHALL leave the FIFO, i_acc/q_acc and overflow untouched, and SHALL produce no dump for the partial symbol.
REQ-031 in_valid=0 cycles SHALL hold all counters and accumulators.

Reset
REQ-032 While rst=1, p, s and the accumulators SHALL be 0, i_acc=0, q_acc=0, sym_strobe=0, the FIFO SHALL be empty (out_valid=0), out_bit=0 and overflow=0.
REQ-033 rst SHALL take priority over sym_align, in_valid and out_ready; a reset mid-symbol SHALL discard the partial symbol.

Verification (IN_W=10, SPS=8, FIFO_DEPTH=4)
REQ-034 Scenario: QPSK mode, continuous valid, samples repeating +100,+50,-100,-50 over 8 samples -> i_acc=400, q_acc=200, sym_strobe pulses once, the bits read out SHALL be 1 then 1.
REQ-035 Scenario: pattern -100,-50,+100,+50 in BPSK mode -> i_acc=-400, q_acc=-200, exactly one bit 0 pushed.
REQ-036 Scenario: pattern -512,0,511,0 -> i_acc=-2046 with no wrap, bit 0; all-zero input -> i_acc=q_acc=0, bits 1,1.
REQ-037 Scenario: out_ready=0, 3 QPSK symbols -> count=4 after 2 symbols, 3rd symbol dropped, overflow=1, first 4 bits intact on drain.
REQ-038 Scenario: sym_align pulsed at s=5 with in_valid=1 -> no dump, next dump exactly 8 accepted samples later (including the align sample); rst asserted at s=3 -> all outputs zero, next dump after 8 fresh samples.
REQ-039 Scenario: in_valid toggling 1/0 every cycle -> results identical to continuous valid, with dump timing tracking accepted samples.
